// File: rtl/weight_dma_engine.sv
// Weight-fetch DMA responder: accepts one (start, length) request, issues pipelined
// word reads with bounded outstanding count, and streams in-order responses back.
module weight_dma_engine #(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 512,
  parameter int MAX_OUT = 8,
  parameter int OUT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_engineer_req,
  input  logic [ADDR_W-1:0] dma_engineer_start_addr,
  input  logic [ADDR_W-1:0] dma_engineer_length,
  output logic              dma_engineer_ack,
  output logic [DATA_W-1:0] dma_engineer_dout,
  output logic              dma_engineer_dout_en,
  output logic              dma_engineer_dout_eop,
  output logic              mem_cmd_valid,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic              mem_cmd_rdy,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [OUT_W-1:0]  MAX_OUT_C = OUT_W'(MAX_OUT);
  localparam logic [OUT_W-1:0]  OUT_ZERO  = {OUT_W{1'b0}};
  localparam logic [OUT_W-1:0]  OUT_ONE   = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [ADDR_W-1:0] rem_cmd_r, rem_cmd_s;
  logic [ADDR_W-1:0] rem_rsp_r, rem_rsp_s;
  logic [OUT_W-1:0]  out_cnt_r, out_cnt_s;
  logic              ack_r, ack_s;
  logic [DATA_W-1:0] dout_r, dout_s;
  logic              dout_en_r, dout_en_s;
  logic              dout_eop_r, dout_eop_s;
  logic              cmd_valid_r, cmd_valid_s;
  logic              busy_r, busy_s;
  logic              err_r, err_s;
  logic              accept_s;
  logic              rsp_s;

  // A response is only consumed while a transfer is active and a read is actually in flight.
  assign accept_s = cmd_valid_r && mem_cmd_rdy;
  assign rsp_s    = mem_rd_valid && (state_r != ST_IDLE) && (out_cnt_r != OUT_ZERO);

  // Next-state and next-output computation; every output is then registered.
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    rem_cmd_s  = rem_cmd_r;
    rem_rsp_s  = rem_rsp_r;
    err_s      = err_r;
    ack_s      = 1'b0;
    dout_s     = dout_r;
    dout_en_s  = 1'b0;
    dout_eop_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // ack_r guards against re-sampling a req that is held through the ack cycle.
        if (dma_engineer_req && !ack_r) begin
          ack_s     = 1'b1;
          addr_s    = dma_engineer_start_addr;
          rem_cmd_s = dma_engineer_length;
          rem_rsp_s = dma_engineer_length;
          if (dma_engineer_length == ADDR_ZERO) begin
            err_s = 1'b1;
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          ack_s = 1'b0;
        end
        if (mem_rd_valid) begin
          err_s = 1'b1;
        end else begin
          dout_en_s = 1'b0;
        end
      end
      ST_ISSUE, ST_DRAIN: begin
        if (accept_s) begin
          addr_s    = addr_r + ADDR_ONE;
          rem_cmd_s = rem_cmd_r - ADDR_ONE;
        end else begin
          addr_s = addr_r;
        end
        if (rsp_s) begin
          dout_s     = mem_rd_data;
          dout_en_s  = 1'b1;
          rem_rsp_s  = rem_rsp_r - ADDR_ONE;
          dout_eop_s = (rem_rsp_r == ADDR_ONE);
        end else if (mem_rd_valid) begin
          err_s = 1'b1;
        end else begin
          dout_en_s = 1'b0;
        end
        // The transfer ends in the cycle the eop word is presented.
        if (dout_eop_r) begin
          state_s = ST_IDLE;
        end else if (rem_cmd_s == ADDR_ZERO) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign out_cnt_s   = out_cnt_r + (accept_s ? OUT_ONE : OUT_ZERO) - (rsp_s ? OUT_ONE : OUT_ZERO);
  assign cmd_valid_s = (state_s == ST_ISSUE) && (rem_cmd_s != ADDR_ZERO) && (out_cnt_s < MAX_OUT_C);
  assign busy_s      = (state_s != ST_IDLE);

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= ADDR_ZERO;
      rem_cmd_r   <= ADDR_ZERO;
      rem_rsp_r   <= ADDR_ZERO;
      out_cnt_r   <= OUT_ZERO;
      ack_r       <= 1'b0;
      dout_r      <= {DATA_W{1'b0}};
      dout_en_r   <= 1'b0;
      dout_eop_r  <= 1'b0;
      cmd_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      rem_cmd_r   <= rem_cmd_s;
      rem_rsp_r   <= rem_rsp_s;
      out_cnt_r   <= out_cnt_s;
      ack_r       <= ack_s;
      dout_r      <= dout_s;
      dout_en_r   <= dout_en_s;
      dout_eop_r  <= dout_eop_s;
      cmd_valid_r <= cmd_valid_s;
      busy_r      <= busy_s;
      err_r       <= err_s;
    end
  end

  assign dma_engineer_ack      = ack_r;
  assign dma_engineer_dout     = dout_r;
  assign dma_engineer_dout_en  = dout_en_r;
  assign dma_engineer_dout_eop = dout_eop_r;
  assign mem_cmd_valid         = cmd_valid_r;
  assign mem_cmd_addr          = addr_r;
  assign busy                  = busy_r;
  assign err                   = err_r;

endmodule

// File: doc/weight_dma_engine.md
# weight_dma_engine

Responder side of the `dma_engineer` request/ack weight-fetch protocol used by the conv layer controllers.
- Accepts one request at a time: a start address and a length in 512-bit words.
- Issues pipelined word reads to the external memory command port, with bounded outstanding reads.
- Streams the returned words to the requester with `dma_engineer_dout_en` / `dma_engineer_dout_eop`.
- Sits between a layer's weight double buffer and the off-chip memory read channel.

## Interface
Parameters:
- `ADDR_W`, 27: width of addresses and lengths, in 512-bit word units.
- `DATA_W`, 512: data word width.
- `MAX_OUT`, 8: maximum outstanding memory reads, range 1..15.
- `OUT_W`, 4: width of the outstanding-read counter; must hold `MAX_OUT`.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `dma_engineer_req`  in  1: level request from the layer controller.
- `dma_engineer_start_addr`  in  ADDR_W: first word address; sampled with req.
- `dma_engineer_length`  in  ADDR_W: word count; sampled with req.
- `dma_engineer_ack`  out  1: one-cycle accept pulse.
- `dma_engineer_dout`  out  DATA_W: returned data word.
- `dma_engineer_dout_en`  out  1: `dma_engineer_dout` valid.
- `dma_engineer_dout_eop`  out  1: last word of the transfer; coincident with dout_en.
- `mem_cmd_valid`  out  1: read command valid.
- `mem_cmd_addr`  out  ADDR_W: word address of the read command.
- `mem_cmd_rdy`  in  1: memory accepts the command when valid && rdy.
- `mem_rd_valid`  in  1: read response valid; in order; no backpressure.
- `mem_rd_data`  in  DATA_W: read response data.
- `busy`  out  1: high whenever the state is not IDLE.
- `err`  out  1: sticky error flag; cleared only by `rst`.

## Operation
State machine: IDLE → ISSUE → DRAIN → IDLE.

IDLE
- When `dma_engineer_req`=1, latch `start_addr` into `addr_r` and `length` into `rem_cmd` and `rem_rsp`.
- Pulse `dma_engineer_ack` next cycle and go to ISSUE.
- If the latched length = 0: ack is still pulsed, `err` is set, and the next state is IDLE. No data and no eop are produced.

ISSUE
- `mem_cmd_valid` = (`rem_cmd` ≠ 0) && (`out_cnt` < `MAX_OUT`).
- `mem_cmd_addr` = `addr_r`.
- On accept (valid && rdy): `addr_r`+1 and `rem_cmd`−1.
- When `rem_cmd` reaches 0, go to DRAIN.
- `addr_r` increments modulo 2^ADDR_W (wraps, no error).

Both ISSUE and DRAIN
- Each `mem_rd_valid` registers `mem_rd_data` into `dma_engineer_dout`, pulses `dout_en` next cycle, and decrements `rem_rsp`.
- `dout_eop` is asserted with the word for which `rem_rsp` was 1.
- That eop cycle is the cycle in which the state returns to IDLE, from DRAIN, or from ISSUE if `rem_cmd` is already 0.

Outstanding-read counter `out_cnt`
- +1 on command accept, −1 on `mem_rd_valid`.
- Both in the same cycle leaves it unchanged.
- It never exceeds `MAX_OUT` and never underflows.

Requester rule: deassert req in the cycle after it sees ack. req is only sampled in IDLE, so a req still high after eop starts a new transfer.

Error conditions:
- `mem_rd_valid` while in IDLE: the data is dropped, `err` is set, and `out_cnt` is unchanged.
- Length 0 request, as above.

Reset:
- Reset values: `dma_engineer_ack`=0, `dout_en`=0, `dout_eop`=0, `dout`=0, `mem_cmd_valid`=0, `mem_cmd_addr`=0, `busy`=0, `err`=0.
- Reset clears all counters and returns the state to IDLE.
- Reset mid-transfer aborts the transfer without eop. Late responses from the aborted transfer set `err`.

## Timing
- req=1 sampled in IDLE at cycle t → `ack` and `busy` high at t+1; first `mem_cmd_valid` at t+1.
- With `mem_cmd_rdy` held at 1 and `out_cnt` < `MAX_OUT`, one command is issued per cycle.
- Response latency: `mem_rd_valid` at cycle r → `dout_en` at r+1.
- eop at cycle e → `busy`=0 at e+1; a new req sampled at e+1 gives ack at e+2.
- A command accept and a response in the same cycle are both processed.

## Test plan
- start_addr=480, length=13, rdy=1, memory latency 3 → one ack; addresses 480..492 in order; 13 dout_en pulses; eop only on the 13th word; data matches; err=0.
- Same request with memory latency 20 → `out_cnt` peaks at exactly 8; no more than 8 commands are in flight; the data order is preserved.
- `mem_cmd_rdy` toggling randomly, length=5 → each address is issued exactly once; 5 words returned; eop on the 5th.
- length=0 → ack pulsed, no dout_en, err=1, busy=0 two cycles after req.
- start_addr=2^27−2, length=4 → addresses 2^27−2, 2^27−1, 0, 1.
- rst asserted after 3 of 10 words → all outputs are 0 the next cycle; trailing `mem_rd_valid` sets err; a new req of length 2 then completes normally.
